// File: rtl/ext_bus_unit_pkg.sv
// Shared types and constants for the external bus unit.
// Covers cycle states, the HRAM window, idle data and the wait counter width.
package ext_bus_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4
    } bus_state_e;

    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_TOP  = 16'hFFFE;
    localparam logic [7:0]  DL_IDLE   = 8'hFF;
    localparam int          WCNT_W    = 4;

endpackage

// File: rtl/ext_bus_wait_ctr.sv
// Saturating wait-state counter with a synchronous clear and an at-max flag.
// It counts T3 clocks spent waiting for memory READY.
module ext_bus_wait_ctr
    import ext_bus_unit_pkg::*;
#(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam logic [WCNT_W-1:0] MAX_V = WCNT_W'(MAX);

    logic [WCNT_W-1:0] cnt_q;
    logic [WCNT_W-1:0] cnt_d;

    assign at_max = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ext_bus_unit.sv
// External bus unit: framed T1..T4 memory cycles with wait states and timeout.
// Defining EXT_BUS_HRAM_BYPASS_EN adds an internal 127-byte HRAM at FF80..FFFE.
module ext_bus_unit
    import ext_bus_unit_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int ADDR_W   = 16
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [ADDR_W-1:0] A,
    input  logic [7:0]        DL_out,
    output logic [7:0]        DL_in,
    input  logic              RD_REQ,
    input  logic              WR_REQ,
    input  logic              BUS_DISABLE,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [ADDR_W-1:0] MA,
    input  logic [7:0]        MD_in,
    output logic [7:0]        MD_out,
    output logic              MD_oe,
    output logic              nRD,
    output logic              nWR,
    output logic              nCS,
    input  logic              READY
);

    bus_state_e        state_q;
    bus_state_e        state_d;
    logic              wr_q;
    logic              wr_d;
    logic [ADDR_W-1:0] ma_q;
    logic [ADDR_W-1:0] ma_d;
    logic [7:0]        md_out_q;
    logic [7:0]        md_out_d;
    logic [7:0]        dl_in_q;
    logic [7:0]        dl_in_d;
    logic              timeout_q;
    logic              timeout_d;

    logic accept;
    logic hit;
    logic hint_q;
    logic wc_en;
    logic wc_max;
    logic t3_exit;

    assign accept = (state_q == S_IDLE) && !hint_q
                  && (RD_REQ || WR_REQ) && !BUS_DISABLE;
    assign wc_en   = (state_q == S_T3) && !READY;
    assign t3_exit = (state_q == S_T3) && (READY || wc_max);

    ext_bus_wait_ctr #(
        .MAX (WAIT_MAX)
    ) u_wait_ctr (
        .clk    (CLK),
        .rst_n  (nRESET),
        .clr    (accept),
        .en     (wc_en),
        .at_max (wc_max)
    );

`ifdef EXT_BUS_HRAM_BYPASS_EN
    logic       hint_d;
    logic [7:0] hram_q [0:126];

    assign hit    = (A >= HRAM_BASE) && (A <= HRAM_TOP);
    assign hint_d = accept && hit;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            hint_q <= 1'b0;
        end else begin
            hint_q <= hint_d;
        end
    end

    // Storage deliberately has no reset.
    always_ff @(posedge CLK) begin
        if (accept && hit && WR_REQ) begin
            hram_q[A[6:0]] <= DL_out;
        end
    end
`else
    assign hit    = 1'b0;
    assign hint_q = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && !hit) state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   if (READY || wc_max) state_d = S_T4;
            S_T4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        nCS   = 1'b1;
        nRD   = 1'b1;
        nWR   = 1'b1;
        MD_oe = 1'b0;
        BUSY  = hint_q;
        DONE  = hint_q;
        unique case (state_q)
            S_IDLE: ;
            S_T1: begin
                nCS  = 1'b0;
                BUSY = 1'b1;
            end
            S_T2, S_T3: begin
                nCS   = 1'b0;
                BUSY  = 1'b1;
                nRD   = wr_q;
                nWR   = !wr_q;
                MD_oe = wr_q;
            end
            S_T4: begin
                nCS   = 1'b0;
                BUSY  = 1'b1;
                MD_oe = wr_q;
                DONE  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_d      = wr_q;
        ma_d      = ma_q;
        md_out_d  = md_out_q;
        dl_in_d   = dl_in_q;
        timeout_d = timeout_q;
        if (accept) begin
            ma_d      = A;
            wr_d      = WR_REQ;
            timeout_d = 1'b0;
            if (WR_REQ) md_out_d = DL_out;
        end
        if (wc_en && wc_max) timeout_d = 1'b1;
        if (t3_exit && !wr_q) dl_in_d = READY ? MD_in : DL_IDLE;
`ifdef EXT_BUS_HRAM_BYPASS_EN
        if (accept && hit && !WR_REQ) dl_in_d = hram_q[A[6:0]];
`endif
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_q      <= 1'b0;
            ma_q      <= '0;
            md_out_q  <= 8'h00;
            dl_in_q   <= DL_IDLE;
            timeout_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            ma_q      <= ma_d;
            md_out_q  <= md_out_d;
            dl_in_q   <= dl_in_d;
            timeout_q <= timeout_d;
        end
    end

    assign MA      = ma_q;
    assign MD_out  = md_out_q;
    assign DL_in   = dl_in_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_ext_bus_unit.sv
// Directed bench for ext_bus_unit: inputs driven and outputs sampled on negedge.
// HRAM checks are built when EXT_BUS_HRAM_BYPASS_EN is defined.
module tb_ext_bus_unit;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [15:0] A;
    logic [7:0]  DL_out;
    logic [7:0]  DL_in;
    logic        RD_REQ;
    logic        WR_REQ;
    logic        BUS_DISABLE;
    logic        BUSY;
    logic        DONE;
    logic        TIMEOUT;
    logic [15:0] MA;
    logic [7:0]  MD_in;
    logic [7:0]  MD_out;
    logic        MD_oe;
    logic        nRD;
    logic        nWR;
    logic        nCS;
    logic        READY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ext_bus_unit dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .A           (A),
        .DL_out      (DL_out),
        .DL_in       (DL_in),
        .RD_REQ      (RD_REQ),
        .WR_REQ      (WR_REQ),
        .BUS_DISABLE (BUS_DISABLE),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .TIMEOUT     (TIMEOUT),
        .MA          (MA),
        .MD_in       (MD_in),
        .MD_out      (MD_out),
        .MD_oe       (MD_oe),
        .nRD         (nRD),
        .nWR         (nWR),
        .nCS         (nCS),
        .READY       (READY)
    );

    task automatic test_reset();
        logic [44:0] exp_v;
        A = 16'h0; DL_out = 8'h0; RD_REQ = 0; WR_REQ = 0;
        BUS_DISABLE = 0; MD_in = 8'h0; READY = 1;
        nRESET = 0;
        #12;
        exp_v = {16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        checks++;
        if ({MA, MD_out, DL_in, MD_oe, BUSY, DONE, TIMEOUT, nRD, nWR, nCS} !== exp_v) begin
            errors++;
            $display("FAIL reset_vals got %h exp %h",
                     {MA, MD_out, DL_in, MD_oe, BUSY, DONE, TIMEOUT, nRD, nWR, nCS}, exp_v);
        end
        @(negedge CLK);
        nRESET = 1;
    endtask

    task automatic test_read();
        logic [5:0] exp_s;
        @(negedge CLK);
        A = 16'hC123; RD_REQ = 1; READY = 1; MD_in = 8'h5A;
        for (int n = 1; n <= 5; n++) begin
            @(negedge CLK);
            exp_s = {!(n <= 4), !(n == 2 || n == 3), 1'b1, 1'b0, (n <= 4), (n == 4)};
            checks++;
            if ({nCS, nRD, nWR, MD_oe, BUSY, DONE} !== exp_s) begin
                errors++;
                $display("FAIL read_strobes clk%0d got %b exp %b", n,
                         {nCS, nRD, nWR, MD_oe, BUSY, DONE}, exp_s);
            end
            if (n == 4) RD_REQ = 0;
        end
        checks++;
        if ({MA, DL_in} !== {16'hC123, 8'h5A}) begin
            errors++;
            $display("FAIL read_data got %h exp %h", {MA, DL_in}, {16'hC123, 8'h5A});
        end
    endtask

    task automatic test_write_wait();
        logic [5:0] exp_s;
        @(negedge CLK);
        A = 16'h8000; DL_out = 8'hA7; WR_REQ = 1; READY = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLK);
            exp_s = {!(n <= 7), 1'b1, !(n >= 2 && n <= 6),
                     (n >= 2 && n <= 7), (n <= 7), (n == 7)};
            checks++;
            if ({nCS, nRD, nWR, MD_oe, BUSY, DONE} !== exp_s) begin
                errors++;
                $display("FAIL write_strobes clk%0d got %b exp %b", n,
                         {nCS, nRD, nWR, MD_oe, BUSY, DONE}, exp_s);
            end
            if (n == 2) begin
                checks++;
                if ({MA, MD_out} !== {16'h8000, 8'hA7}) begin
                    errors++;
                    $display("FAIL write_bus got %h exp %h", {MA, MD_out}, {16'h8000, 8'hA7});
                end
            end
            if (n == 6) READY = 1;
            if (n == 7) WR_REQ = 0;
        end
        checks++;
        if (DL_in !== 8'h5A) begin
            errors++;
            $display("FAIL write_dl_hold got %h exp 5a", DL_in);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp_s;
        @(negedge CLK);
        A = 16'h4000; RD_REQ = 1; READY = 0; MD_in = 8'h99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            exp_s = {(n <= 19), (n == 19), (n >= 19)};
            checks++;
            if ({BUSY, DONE, TIMEOUT} !== exp_s) begin
                errors++;
                $display("FAIL timeout_seq clk%0d got %b exp %b", n, {BUSY, DONE, TIMEOUT}, exp_s);
            end
            if (n == 19) begin
                RD_REQ = 0;
                checks++;
                if (DL_in !== 8'hFF) begin
                    errors++;
                    $display("FAIL timeout_dl got %h exp ff", DL_in);
                end
            end
        end
        READY = 1;
        A = 16'h0001; MD_in = 8'h66; RD_REQ = 1;
        @(negedge CLK);
        checks++;
        if ({TIMEOUT, BUSY} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_clear got %b exp 01", {TIMEOUT, BUSY});
        end
        repeat (3) @(negedge CLK);
        RD_REQ = 0;
        checks++;
        if ({DONE, DL_in} !== {1'b1, 8'h66}) begin
            errors++;
            $display("FAIL timeout_next_read got %h exp %h", {DONE, DL_in}, {1'b1, 8'h66});
        end
    endtask

    task automatic test_both_req();
        @(negedge CLK);
        A = 16'h1234; DL_out = 8'h33; RD_REQ = 1; WR_REQ = 1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge CLK);
            if (n == 2) begin
                checks++;
                if ({nRD, nWR, MD_oe, MA, MD_out} !== {3'b101, 16'h1234, 8'h33}) begin
                    errors++;
                    $display("FAIL both_req got %h exp %h", {nRD, nWR, MD_oe, MA, MD_out},
                             {3'b101, 16'h1234, 8'h33});
                end
            end
            if (n == 4) begin
                RD_REQ = 0; WR_REQ = 0;
            end
        end
        checks++;
        if (DL_in !== 8'h66) begin
            errors++;
            $display("FAIL both_dl_hold got %h exp 66", DL_in);
        end
    endtask

    task automatic test_bus_disable();
        @(negedge CLK);
        A = 16'h5555; BUS_DISABLE = 1; RD_REQ = 1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge CLK);
            checks++;
            if ({BUSY, nCS, nRD, nWR} !== 4'b0111) begin
                errors++;
                $display("FAIL disable_idle clk%0d got %b exp 0111", n, {BUSY, nCS, nRD, nWR});
            end
        end
        BUS_DISABLE = 0; MD_in = 8'h44; READY = 1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge CLK);
            checks++;
            if ({BUSY, DONE} !== {(n <= 4), (n == 4)}) begin
                errors++;
                $display("FAIL disable_mid clk%0d got %b exp %b", n, {BUSY, DONE},
                         {(n <= 4), (n == 4)});
            end
            if (n == 2) BUS_DISABLE = 1;
        end
        RD_REQ = 0; BUS_DISABLE = 0;
        checks++;
        if (DL_in !== 8'h44) begin
            errors++;
            $display("FAIL disable_dl got %h exp 44", DL_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_s;
        @(negedge CLK);
        A = 16'h2000; MD_in = 8'h11; RD_REQ = 1; READY = 1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            exp_s = {(n <= 4) || (n >= 6 && n <= 9), (n == 4) || (n == 9)};
            checks++;
            if ({BUSY, DONE} !== exp_s) begin
                errors++;
                $display("FAIL b2b_seq clk%0d got %b exp %b", n, {BUSY, DONE}, exp_s);
            end
            if (n == 4) begin
                MD_in = 8'h22; A = 16'h2001;
            end
            if (n == 5) begin
                checks++;
                if (DL_in !== 8'h11) begin
                    errors++;
                    $display("FAIL b2b_first got %h exp 11", DL_in);
                end
            end
            if (n == 9) RD_REQ = 0;
        end
        checks++;
        if ({MA, DL_in} !== {16'h2001, 8'h22}) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", {MA, DL_in}, {16'h2001, 8'h22});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        A = 16'h3000; MD_in = 8'h55; RD_REQ = 1; READY = 1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({nCS, nRD} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_t2 got %b exp 00", {nCS, nRD});
        end
        #2 nRESET = 0;
        #1;
        checks++;
        if ({nCS, nRD, nWR, BUSY, DONE, DL_in, MA} !== {5'b11100, 8'hFF, 16'h0000}) begin
            errors++;
            $display("FAIL rstmid_async got %h exp %h", {nCS, nRD, nWR, BUSY, DONE, DL_in, MA},
                     {5'b11100, 8'hFF, 16'h0000});
        end
        RD_REQ = 0;
        @(negedge CLK);
        nRESET = 1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge CLK);
            checks++;
            if ({BUSY, DONE, nCS} !== 3'b001) begin
                errors++;
                $display("FAIL rstmid_after clk%0d got %b exp 001", n, {BUSY, DONE, nCS});
            end
        end
    endtask

`ifdef EXT_BUS_HRAM_BYPASS_EN
    task automatic test_hram();
        @(negedge CLK);
        A = 16'hFF90; DL_out = 8'h3C; WR_REQ = 1;
        @(negedge CLK);
        WR_REQ = 0;
        checks++;
        if ({DONE, nCS, nRD, nWR} !== 4'b1111) begin
            errors++;
            $display("FAIL hram_wr got %b exp 1111", {DONE, nCS, nRD, nWR});
        end
        @(negedge CLK);
        checks++;
        if ({DONE, BUSY} !== 2'b00) begin
            errors++;
            $display("FAIL hram_wr_end got %b exp 00", {DONE, BUSY});
        end
        RD_REQ = 1; MD_in = 8'h00;
        @(negedge CLK);
        RD_REQ = 0;
        checks++;
        if ({DONE, nCS, nRD, nWR, DL_in} !== {4'b1111, 8'h3C}) begin
            errors++;
            $display("FAIL hram_rd got %h exp %h", {DONE, nCS, nRD, nWR, DL_in}, {4'b1111, 8'h3C});
        end
        @(negedge CLK);
        A = 16'hFFFF; RD_REQ = 1; MD_in = 8'h81;
        @(negedge CLK);
        checks++;
        if ({nCS, DONE} !== 2'b00) begin
            errors++;
            $display("FAIL hram_edge got %b exp 00", {nCS, DONE});
        end
        repeat (3) @(negedge CLK);
        RD_REQ = 0;
        @(negedge CLK);
    endtask
`else
    task automatic test_hram();
        @(negedge CLK);
        A = 16'hFF90; RD_REQ = 1; MD_in = 8'h6E; READY = 1;
        @(negedge CLK);
        checks++;
        if ({nCS, DONE, BUSY} !== 3'b001) begin
            errors++;
            $display("FAIL hram_absent got %b exp 001", {nCS, DONE, BUSY});
        end
        repeat (3) @(negedge CLK);
        RD_REQ = 0;
        checks++;
        if ({DONE, DL_in} !== {1'b1, 8'h6E}) begin
            errors++;
            $display("FAIL hram_absent_rd got %h exp %h", {DONE, DL_in}, {1'b1, 8'h6E});
        end
        @(negedge CLK);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_timeout();
        test_both_req();
        test_bus_disable();
        test_back_to_back();
        test_reset_mid();
        test_hram();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_bus_unit.md
Name: ext_bus_unit

Overview:
- Sits directly downstream of the bottom datapath.
- Consumes the core address bus A[15:0], the internal databus value and the core read/write requests.
- Runs framed external memory cycles (T1..T4) with optional memory wait states.
- Returns read data to the core and reports completion.

Parameters:
- WAIT_MAX, 15: maximum wait-state clocks inserted before a forced completion (timeout).
- ADDR_W, 16: external address width.

Ports:
- CLK  in  1  single core clock; all state changes on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- A  in  16  core address bus (from IncDec).
- DL_out  in  8  core write data (internal databus value).
- DL_in  out  8  read data latched for the core.
- RD_REQ  in  1  core read request, sampled in IDLE.
- WR_REQ  in  1  core write request, sampled in IDLE.
- BUS_DISABLE  in  1  1 = external bus frozen, no new cycle started.
- BUSY  out  1  1 while a cycle is in flight.
- DONE  out  1  one-clock pulse at cycle completion.
- TIMEOUT  out  1  sticky; set when WAIT_MAX is exhausted; cleared by reset or the next accepted request.
- MA  out  16  external address.
- MD_in  in  8  external data in.
- MD_out  out  8  external data out.
- MD_oe  out  1  external data output enable.
- nRD  out  1  external read strobe, active low.
- nWR  out  1  external write strobe, active low.
- nCS  out  1  external chip select, active low.
- READY  in  1  memory ready; 0 inserts wait states in T3.

Behaviour:
- Reset (async, nRESET=0):
  - State = IDLE.
  - MA = 16'h0000, MD_out = 8'h00, DL_in = 8'hFF.
  - MD_oe = 0, BUSY = 0, DONE = 0, TIMEOUT = 0.
  - nRD = nWR = nCS = 1.
- Reset mid-cycle aborts immediately. Strobes deassert asynchronously; no DONE is issued.
- States: IDLE, T1, T2, T3, T4.
- IDLE:
  - Accepts a request if (RD_REQ | WR_REQ) & ~BUS_DISABLE.
  - If both requests are asserted together, WR wins; RD is dropped, not queued.
  - On accept: latch A -> MA, latch DL_out -> MD_out (write only), latch the direction, clear TIMEOUT, go to T1.
  - Otherwise MA holds its last value.
- T1: nCS = 0, BUSY = 1. Go to T2.
- T2:
  - Read: nRD = 0.
  - Write: MD_oe = 1, then nWR = 0.
  - Go to T3.
- T3:
  - If READY = 0 and wait counter < WAIT_MAX: stay in T3, counter++.
  - If READY = 1 or counter == WAIT_MAX: go to T4. On counter == WAIT_MAX with READY still 0, set TIMEOUT.
  - Read: capture MD_in -> DL_in on the T3 -> T4 edge. On timeout capture 8'hFF instead.
- T4:
  - Deassert nRD/nWR; keep nCS = 0 and MD_oe held for one clock of hold time.
  - Pulse DONE for this clock.
  - Go to IDLE, where nCS = 1, MD_oe = 0, BUSY = 0.
- Latency:
  - Zero-wait access = 4 clocks from accept to DONE; DONE is asserted in T4.
  - Each wait state adds 1 clock.
  - A back-to-back request can be accepted in the clock after T4.
- The wait counter is 4 bits and saturates; it is cleared on entry to T1.
- BUS_DISABLE rising during a cycle does not abort it; it only blocks the next accept.
- Requests arriving while BUSY are ignored. The core must hold the request until DONE.
- DL_in holds its value until the next completed read.

Optional Feature:
- Macro EXT_BUS_HRAM_BYPASS_EN.
- When defined:
  - An accepted request with MA in 16'hFF80..16'hFFFE is internal.
  - No T1..T4 is run; nCS/nRD/nWR stay 1.
  - A one-clock internal cycle pulses DONE the clock after accept.
  - Reads come from a 127x8 register file; writes go to it.
  - The file is not reset.
- When undefined: all addresses run external cycles and no storage exists.

Decomposition:
- Shared package:
  - state enum (IDLE, T1..T4);
  - HRAM_BASE 16'hFF80 and HRAM_TOP 16'hFFFE;
  - DL_IDLE 8'hFF;
  - wait counter width constant.
- One sub-module, ext_bus_wait_ctr: saturating wait counter with clear, enable and at-max flag.
- The HRAM file stays inline under the macro.

Test Plan:
- Reset mid-T2 of a read -> nRD = nCS = 1 at once, no DONE, state IDLE, DL_in = 8'hFF.
- Read A = 16'hC123, READY = 1, MD_in = 8'h5A:
  - nCS low T1..T4, nRD low T2..T3;
  - DONE on the 4th clock after accept;
  - DL_in = 8'h5A.
- Write A = 16'h8000, DL_out = 8'hA7, READY held 0 for 3 clocks:
  - MD_oe = 1 and MD_out = 8'hA7;
  - nWR low T2..T3 plus 3 waits;
  - DONE at clock 7.
- READY stuck 0 on a read -> after 15 waits, TIMEOUT = 1, DL_in = 8'hFF, DONE pulses. The next accepted request clears TIMEOUT.
- RD_REQ and WR_REQ together -> write cycle. BUS_DISABLE = 1 in IDLE with a request -> no strobes, BUSY stays 0.
- With EXT_BUS_HRAM_BYPASS_EN, write 8'h3C to 16'hFF90 then read it back:
  - no external strobes;
  - DONE 1 clock after each accept;
  - DL_in = 8'h3C.
